// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters, one access in flight at a time.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   we,
    input  logic [NUM_REQ*32-1:0] addr,
    input  logic [NUM_REQ*32-1:0] wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   err,
    output logic [NUM_REQ-1:0]   rvalid,
    output logic [31:0]          rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] DEPTH_WORDS = 32'(1) << DATA_DEPTH;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, cur, winner;
    logic          found, sel_we, in_range;
    logic [31:0]   sel_addr, sel_wdata;
    int            idx;

    // Scan starting at ptr and wrapping; the first set req wins.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                winner    = PW'(idx);
                sel_we    = we[idx];
                sel_addr  = addr[idx*32 +: 32];
                sel_wdata = wdata[idx*32 +: 32];
            end
        end
    end

    // Signed address: negative values have bit 31 set.
    assign in_range = !sel_addr[31] && (sel_addr < DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = mem_read ? RDWAIT : IDLE;
            RDWAIT:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack       <= '0;
            err       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ptr       <= '0;
            cur       <= '0;
        end else begin
            ack       <= '0;
            err       <= '0;
            rvalid    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    ack[winner] <= 1'b1;
                    err[winner] <= !in_range;
                    mem_read    <= in_range && !sel_we;
                    mem_write   <= in_range && sel_we;
                    mem_addr    <= sel_addr;
                    mem_wdata   <= sel_wdata;
                    cur         <= winner;
`ifdef ARB_FIXED_PRIO_EN
                    ptr         <= '0;
`else
                    ptr         <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
                end
                RDWAIT: begin
                    rdata       <= mem_rdata;
                    rvalid[cur] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration order, throughput, reset and RESP timing.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req, we;
    logic [127:0] addr, wdata;
    logic [3:0]   ack, err, rvalid;
    logic [31:0]  rdata, mem_addr, mem_wdata, mem_rdata;
    logic         mem_read, mem_write;

    int checks = 0;
    int errors = 0;
    int ack_id[8];
    int ack_t[8];
    int ack_n;

    mem_port_arbiter #(.NUM_REQ(4), .DATA_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rvalid(rvalid), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, data valid the cycle after the read edge.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[3:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= ram[mem_addr[3:0]];
    end

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Collect up to n acks, recording winner index and negedge count of each.
    task automatic watch_acks(input int n);
        ack_n = 0;
        for (int c = 0; c < 80 && ack_n < n; c++) begin
            @(negedge clk);
            if (ack != 4'b0) begin
                ack_id[ack_n] = -1;
                if ($countones(ack) == 1)
                    for (int b = 0; b < 4; b++) if (ack[b]) ack_id[ack_n] = b;
                ack_t[ack_n] = c;
                ack_n++;
            end
        end
        if (ack_n < n) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ack_n, n);
        end
    endtask

    task automatic do_txn(input int i, input vec_t v);
        logic [3:0] oh;
        oh = 4'b1 << v.id;
        req = '0;
        req[v.id] = 1'b1;
        we[v.id] = v.wr;
        addr[v.id*32 +: 32] = v.a;
        wdata[v.id*32 +: 32] = v.d;
        watch_acks(1);
        if (ack_n == 1) begin
            chk($sformatf("t%0d_ack", i), ack, oh);
            chk($sformatf("t%0d_err", i), err, v.e ? oh : 4'b0);
            chk($sformatf("t%0d_mem_write", i), mem_write, v.wr && !v.e);
            chk($sformatf("t%0d_mem_read", i), mem_read, !v.wr && !v.e);
            if (!v.e) chk($sformatf("t%0d_mem_addr", i), mem_addr, v.a);
            if (!v.e && v.wr) chk($sformatf("t%0d_mem_wdata", i), mem_wdata, v.d);
        end
        @(posedge clk);
        #1 req = '0;
        if (!v.wr && !v.e) begin
            @(negedge clk);
            chk($sformatf("t%0d_rvalid_early", i), rvalid, 4'b0);
            @(negedge clk);
            chk($sformatf("t%0d_rvalid", i), rvalid, oh);
            chk($sformatf("t%0d_rdata", i), rdata, v.exp_rd);
        end else begin
            repeat (2) begin
                @(negedge clk);
                chk($sformatf("t%0d_no_rvalid", i), rvalid, 4'b0);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{0, 1'b1, 32'd3,          32'h0000_0055, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 32'd3,          32'h0,         1'b0, 32'h0000_0055};
        tbl[2]  = '{1, 1'b1, 32'd15,         32'hA5A5_0001, 1'b0, 32'h0};
        tbl[3]  = '{2, 1'b0, 32'd15,         32'h0,         1'b0, 32'hA5A5_0001};
        tbl[4]  = '{3, 1'b1, 32'd0,          32'hFFFF_FFF9, 1'b0, 32'h0};
        tbl[5]  = '{1, 1'b0, 32'd0,          32'h0,         1'b0, 32'hFFFF_FFF9};
        tbl[6]  = '{0, 1'b1, 32'd16,         32'h1234_5678, 1'b1, 32'h0};
        tbl[7]  = '{2, 1'b0, 32'hFFFF_FFFF,  32'h0,         1'b1, 32'h0};
        tbl[8]  = '{3, 1'b0, 32'd3,          32'h0,         1'b0, 32'h0000_0055};
        tbl[9]  = '{1, 1'b0, 32'd0,          32'h0,         1'b0, 32'hFFFF_FFF9};
        tbl[10] = '{2, 1'b1, 32'h8000_0000,  32'hDEAD_BEEF, 1'b1, 32'h0};

        reset = 1'b1;
        req   = 4'hF;
        we    = '0;
        addr  = '0;
        wdata = '0;

        // Reset held with all requests high: everything quiet.
        repeat (2) begin
            @(negedge clk);
            chk("rst_ack", ack, 4'b0);
            chk("rst_err", err, 4'b0);
            chk("rst_rvalid", rvalid, 4'b0);
            chk("rst_strobes", {mem_read, mem_write}, 2'b00);
            chk("rst_rdata", rdata, 32'h0);
        end
        req = '0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) do_txn(i, tbl[i]);

        // All four reading and holding req: arbitration order and 4-cycle spacing.
        do_reset();
        for (int i = 0; i < 4; i++) addr[i*32 +: 32] = 32'(i);
        we  = 4'h0;
        req = 4'hF;
        watch_acks(5);
        for (int k = 0; k < ack_n; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk($sformatf("rr_order%0d", k), ack_id[k], 0);
`else
            chk($sformatf("rr_order%0d", k), ack_id[k], k % 4);
`endif
            if (k > 0) chk($sformatf("rd_spacing%0d", k), ack_t[k] - ack_t[k-1], 4);
        end
        @(posedge clk);
        #1 req = '0;
        repeat (4) @(negedge clk);

        // Back-to-back writes from requesters 0 and 1: one every 2 cycles.
        we = 4'hF;
        wdata[31:0]  = 32'h0000_1111;
        wdata[63:32] = 32'h0000_2222;
        req = 4'b0011;
        watch_acks(3);
        for (int k = 0; k < ack_n; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk($sformatf("wr_order%0d", k), ack_id[k], 0);
`else
            chk($sformatf("wr_order%0d", k), ack_id[k], (k % 2 == 0) ? 1 : 0);
`endif
            if (k > 0) chk($sformatf("wr_spacing%0d", k), ack_t[k] - ack_t[k-1], 2);
        end
        @(posedge clk);
        #1 req = '0;
        repeat (2) @(negedge clk);

        // Reset during RDWAIT: the read is abandoned, pointer restarts at 0.
        we = 4'h0;
        addr[31:0] = 32'd3;
        req = 4'b0001;
        watch_acks(1);
        @(posedge clk);
        #1 begin reset = 1'b1; req = 4'b1010; end
        repeat (2) begin
            @(negedge clk);
            chk("rdwait_rst_rvalid", rvalid, 4'b0);
            chk("rdwait_rst_ack", ack, 4'b0);
        end
        reset = 1'b0;
        watch_acks(1);
        if (ack_n == 1) chk("post_rst_first_ack", ack_id[0], 1);
        chk("post_rst_no_rvalid", rvalid, 4'b0);
        @(posedge clk);
        #1 req = '0;
        repeat (4) @(negedge clk);

        // Requester 2 arrives during RESP of requester 1's read.
        addr[63:32] = 32'd15;
        req = 4'b0010;
        watch_acks(1);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("resp_rvalid", rvalid, 4'b0010);
        chk("resp_rdata", rdata, 32'hA5A5_0001);
        we[2] = 1'b1;
        addr[95:64] = 32'd5;
        req = 4'b0100;
        @(negedge clk);
        chk("after_resp_idle_ack", ack, 4'b0);
        chk("after_resp_rvalid", rvalid, 4'b0);
        chk("rdata_held", rdata, 32'hA5A5_0001);
        @(negedge clk);
        chk("after_resp_ack2", ack, 4'b0100);
        chk("after_resp_write", mem_write, 1'b1);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
